// File: rtl/usb_utm_rx_if.sv
`default_nettype none
// ============================================================================
// Module   : usb_utm_rx_if
// Purpose  : Bundles the full-speed line inputs and the UTMI receive outputs
//            of the UTM receiver.
//            master : the receiver (samples the line, drives the rx outputs)
//            slave  : the link/frontend side (drives the line, consumes rx)
// Signals  : dp_rx, dn_rx  - asynchronous D+/D- from the frontend
//            tx_oen        - transmitter owns the line, blocks reception
//            data_out      - received byte
//            rx_valid      - data_out valid, one-cycle pulse
//            rx_active     - packet in progress
//            rx_error      - receive error, one-cycle pulse
//            line_state    - synchronised {dn,dp}
// Revision : 1.0 - initial release
// ============================================================================
interface usb_utm_rx_if;
  typedef logic [7:0] bus8_t;

  logic       dp_rx;
  logic       dn_rx;
  logic       tx_oen;
  bus8_t      data_out;
  logic       rx_valid;
  logic       rx_active;
  logic       rx_error;
  logic [1:0] line_state;

  modport master (
    input  dp_rx, dn_rx, tx_oen,
    output data_out, rx_valid, rx_active, rx_error, line_state
  );

  modport slave (
    output dp_rx, dn_rx, tx_oen,
    input  data_out, rx_valid, rx_active, rx_error, line_state
  );
endinterface
`default_nettype wire

// File: rtl/usb_utm_rx.sv
`default_nettype none
// ============================================================================
// Module   : usb_utm_rx
// Purpose  : UTM receive path. Synchronises D+/D-, recovers bit timing from
//            line transitions, NRZI-decodes, detects SYNC, removes stuffed
//            bits, assembles LSB-first bytes and detects EOP.
// Ports    : clk  - clock
//            rst  - synchronous active-high reset
//            bus  - usb_utm_rx_if.master (line inputs, tx_oen, rx outputs)
// Revision : 1.0 - initial release
// ============================================================================
module usb_utm_rx #(
  parameter int CLK_PER_BIT    = 4,
  parameter int STUFF_BITS_N   = 6,
  parameter int SYNC_MIN_ZEROS = 5
) (
  input  wire logic    clk,
  input  wire logic    rst,
  usb_utm_rx_if.master bus
);

  localparam int c_PH_W = $clog2(CLK_PER_BIT);
  localparam int c_ZC_W = $clog2(SYNC_MIN_ZEROS + 1);
  localparam int c_OC_W = $clog2(STUFF_BITS_N + 1);

  localparam logic [c_PH_W-1:0] c_SMP_PHASE = c_PH_W'(CLK_PER_BIT / 2 - 1);
  localparam logic [c_PH_W-1:0] c_PH_ONE    = c_PH_W'(1);
  localparam logic [c_ZC_W-1:0] c_ZC_MAX    = c_ZC_W'(SYNC_MIN_ZEROS);
  localparam logic [c_ZC_W-1:0] c_ZC_ONE    = c_ZC_W'(1);
  localparam logic [c_OC_W-1:0] c_OC_MAX    = c_OC_W'(STUFF_BITS_N);
  localparam logic [c_OC_W-1:0] c_OC_ONE    = c_OC_W'(1);

  typedef enum logic [2:0] {
    RX_IDLE_S  = 3'd0,
    RX_SYNC_S  = 3'd1,
    RX_DATA_S  = 3'd2,
    RX_EOP_S   = 3'd3,
    RX_ABORT_S = 3'd4
  } state_t;

  // Line synchroniser and bit-timing recovery
  logic              r_dp_s1, r_dn_s1;
  logic [1:0]        r_ls;
  logic [1:0]        r_prev_ls;
  logic [c_PH_W-1:0] r_phase;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dp_s1   <= 1'b0;
      r_dn_s1   <= 1'b0;
      r_ls      <= 2'b00;
      r_prev_ls <= 2'b00;
      r_phase   <= '0;
    end else begin
      r_dp_s1   <= bus.dp_rx;
      r_dn_s1   <= bus.dn_rx;
      r_ls      <= {r_dn_s1, r_dp_s1};
      r_prev_ls <= r_ls;
      // Every edge re-centres the sampling point; power-of-two wrap is free.
      r_phase   <= (r_ls != r_prev_ls) ? '0 : r_phase + c_PH_ONE;
    end
  end

  logic w_stb, w_se0, w_smp_k, w_bit;
  assign w_stb   = (r_phase == c_SMP_PHASE);
  assign w_se0   = (r_ls == 2'b00) || (r_ls == 2'b11);  // SE1 handled as SE0
  assign w_smp_k = (r_ls == 2'b10);

  // Receive FSM and datapath registers
  state_t            r_state, w_state_nx;
  logic              r_last_k, w_last_k_nx;      // previous J/K sample was K
  logic [c_ZC_W-1:0] r_zero_cnt, w_zero_nx;
  logic [c_OC_W-1:0] r_ones_cnt, w_ones_nx;
  logic [2:0]        r_bit_cnt, w_bit_nx;
  logic [6:0]        r_shift, w_shift_nx;        // bits collected so far, LSB first
  logic [7:0]        r_data, w_data_nx;
  logic              r_valid, w_valid_nx;
  logic              r_active, w_active_nx;
  logic              r_error, w_error_nx;
  logic [7:0]        w_byte;

  // NRZI: no line change across a bit cell decodes as 1.
  assign w_bit  = (w_smp_k == r_last_k);
  assign w_byte = {w_bit, r_shift};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= RX_IDLE_S;
      r_last_k   <= 1'b0;
      r_zero_cnt <= '0;
      r_ones_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_active   <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_last_k   <= w_last_k_nx;
      r_zero_cnt <= w_zero_nx;
      r_ones_cnt <= w_ones_nx;
      r_bit_cnt  <= w_bit_nx;
      r_shift    <= w_shift_nx;
      r_data     <= w_data_nx;
      r_valid    <= w_valid_nx;
      r_active   <= w_active_nx;
      r_error    <= w_error_nx;
    end
  end

  always_comb begin
    w_state_nx  = r_state;
    w_last_k_nx = r_last_k;
    w_zero_nx   = r_zero_cnt;
    w_ones_nx   = r_ones_cnt;
    w_bit_nx    = r_bit_cnt;
    w_shift_nx  = r_shift;
    w_data_nx   = r_data;
    w_valid_nx  = 1'b0;
    w_error_nx  = 1'b0;
    w_active_nx = r_active;

    if (bus.tx_oen) begin
      // Pretending the last sample was K forces a fresh J-to-K before SYNC.
      w_state_nx  = RX_IDLE_S;
      w_active_nx = 1'b0;
      w_last_k_nx = 1'b1;
      w_zero_nx   = '0;
      w_ones_nx   = '0;
      w_bit_nx    = '0;
    end else if (w_stb) begin
      case (r_state)
        RX_IDLE_S: begin
          if (w_se0 || !w_smp_k) begin
            w_last_k_nx = 1'b0;
          end else if (!r_last_k) begin
            w_state_nx  = RX_SYNC_S;
            w_zero_nx   = c_ZC_ONE;
            w_last_k_nx = 1'b1;
          end
        end

        RX_SYNC_S: begin
          if (w_se0) begin
            w_state_nx  = RX_IDLE_S;
            w_last_k_nx = 1'b0;
          end else begin
            w_last_k_nx = w_smp_k;
            if (!w_bit) begin
              if (r_zero_cnt != c_ZC_MAX) w_zero_nx = r_zero_cnt + c_ZC_ONE;
            end else if (r_zero_cnt >= c_ZC_MAX) begin
              w_state_nx  = RX_DATA_S;
              w_active_nx = 1'b1;
              w_bit_nx    = '0;
              w_ones_nx   = '0;
            end else begin
              w_state_nx = RX_IDLE_S;
            end
          end
        end

        RX_DATA_S: begin
          if (w_se0) begin
            w_state_nx = RX_EOP_S;
            w_error_nx = (r_bit_cnt != 3'd0);
            w_bit_nx   = '0;
          end else begin
            w_last_k_nx = w_smp_k;
            if (r_ones_cnt == c_OC_MAX) begin
              // This cell must be the stuffed zero; it carries no data.
              if (w_bit) begin
                w_error_nx  = 1'b1;
                w_active_nx = 1'b0;
                w_state_nx  = RX_ABORT_S;
              end
              w_ones_nx = '0;
            end else begin
              w_shift_nx = w_byte[7:1];
              w_ones_nx  = w_bit ? r_ones_cnt + c_OC_ONE : '0;
              if (r_bit_cnt == 3'd7) begin
                w_data_nx  = w_byte;
                w_valid_nx = 1'b1;
                w_bit_nx   = '0;
              end else begin
                w_bit_nx = r_bit_cnt + 3'd1;
              end
            end
          end
        end

        RX_EOP_S: begin
          if (!w_se0) begin
            w_active_nx = 1'b0;
            if (w_smp_k) begin
              w_error_nx = 1'b1;
              w_state_nx = RX_ABORT_S;
            end else begin
              w_state_nx  = RX_IDLE_S;
              w_last_k_nx = 1'b0;
            end
          end
        end

        RX_ABORT_S: begin
          w_active_nx = 1'b0;
          if (!w_se0 && !w_smp_k) begin
            w_state_nx  = RX_IDLE_S;
            w_last_k_nx = 1'b0;
          end
        end

        default: w_state_nx = RX_IDLE_S;
      endcase
    end
  end

  assign bus.data_out   = r_data;
  assign bus.rx_valid   = r_valid;
  assign bus.rx_active  = r_active;
  assign bus.rx_error   = r_error;
  assign bus.line_state = r_ls;

endmodule
`default_nettype wire
